// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit
// Purpose  : Detects pipeline hazards that bypassing cannot resolve (load-use,
//            taken-branch wrong path, data-memory wait) and drives PC/IF-ID/
//            ID-EX enables and flushes plus a global hold for the back end.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int FLUSH_CYCLES = 1,
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_pipe_hold,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_wait_cnt
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_TIMEOUT_M1 = CNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [2:0]       C_FCNT_LOAD  = 3'(FLUSH_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_fcnt;
    logic [2:0]       w_fcnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] r_run_cnt;
    logic             r_mem_timeout;

    logic             w_freeze;
    logic             w_lu;
    logic             w_do_flush;
    logic             w_do_stall;

    assign w_freeze = i_mem_req & ~i_mem_ready;
    assign w_lu     = i_ex_mem_read & (i_ex_rd != 5'd0) &
                      ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) |
                       (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));

    // Prioritised output decode and next-state selection
    always_comb begin
        o_pc_write   = 1'b1;
        o_ifid_write = 1'b1;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        o_pipe_hold  = 1'b0;
        w_do_flush   = 1'b0;
        w_do_stall   = 1'b0;
        w_state_nxt  = r_state;
        w_fcnt_nxt   = r_fcnt;
        if (!rst_n) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (w_freeze) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_pipe_hold  = 1'b1;
        end else if ((r_state == ST_FLUSH) || i_branch_taken) begin
            // Wrong-path squash; load-use on the wrong path is irrelevant
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            w_do_flush   = 1'b1;
            if (r_state == ST_FLUSH) begin
                w_fcnt_nxt = r_fcnt - 3'd1;
                if (r_fcnt == 3'd1) begin
                    w_state_nxt = ST_RUN;
                end
            end else if (FLUSH_CYCLES > 1) begin
                w_state_nxt = ST_FLUSH;
                w_fcnt_nxt  = C_FCNT_LOAD;
            end
        end else if (w_lu) begin
            // Single bubble: the load moves on to MEM next cycle
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_idex_flush = 1'b1;
            w_do_stall   = 1'b1;
        end
    end

    // Flush FSM state and down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_fcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            if (w_do_stall && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_do_flush && (r_flush_cnt != C_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (w_freeze && (r_wait_cnt != C_CNT_MAX)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    // Consecutive-freeze tracking and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt     <= '0;
            r_mem_timeout <= 1'b0;
        end else if (w_freeze) begin
            if (r_run_cnt != C_CNT_MAX) begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end
            if (r_run_cnt == C_TIMEOUT_M1) begin
                r_mem_timeout <= 1'b1;
            end
        end else begin
            r_run_cnt <= '0;
        end
    end

    assign o_mem_timeout = r_mem_timeout;
    assign o_stall_cnt   = r_stall_cnt;
    assign o_flush_cnt   = r_flush_cnt;
    assign o_wait_cnt    = r_wait_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_unit
// Purpose  : Directed and randomized checks of hazard_stall_unit against a
//            cycle-level reference model of the hazard rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

    localparam int FC   = 3;
    localparam int WT   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          rs1_used, rs2_used, mem_read, br, req, rdy;
    logic          pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_flush_left;
    int m_stall, m_flush, m_wait, m_run;
    bit m_timeout;

    always #5 clk = ~clk;

    hazard_stall_unit #(.FLUSH_CYCLES(FC), .WAIT_TIMEOUT(WT), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_rs1_used (rs1_used),
        .i_id_rs2_used (rs2_used),
        .i_ex_rd       (ex_rd),
        .i_ex_mem_read (mem_read),
        .i_branch_taken(br),
        .i_mem_req     (req),
        .i_mem_ready   (rdy),
        .o_pc_write    (pc_write),
        .o_ifid_write  (ifid_write),
        .o_ifid_flush  (ifid_flush),
        .o_idex_flush  (idex_flush),
        .o_pipe_hold   (pipe_hold),
        .o_mem_timeout (mem_timeout),
        .o_stall_cnt   (stall_cnt),
        .o_flush_cnt   (flush_cnt),
        .o_wait_cnt    (wait_cnt)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_freeze();
        return req && !rdy;
    endfunction

    function automatic bit m_loaduse();
        if (!mem_read || ex_rd == 0) return 1'b0;
        return (rs1_used && id_rs1 == ex_rd) || (rs2_used && id_rs2 == ex_rd);
    endfunction

    function automatic bit m_flushing();
        return (m_flush_left > 0) || br;
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        m_flush_left = 0;
        m_stall = 0; m_flush = 0; m_wait = 0; m_run = 0;
        m_timeout = 1'b0;
    endtask

    // Expected outputs {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold}
    task automatic check_all();
        logic [4:0] e;
        if (!rst_n)              e = 5'b00110;
        else if (m_freeze())     e = 5'b00001;
        else if (m_flushing())   e = 5'b11110;
        else if (m_loaduse())    e = 5'b00010;
        else                     e = 5'b11000;
        check("pc_write",    int'(pc_write),    int'(e[4]));
        check("ifid_write",  int'(ifid_write),  int'(e[3]));
        check("ifid_flush",  int'(ifid_flush),  int'(e[2]));
        check("idex_flush",  int'(idex_flush),  int'(e[1]));
        check("pipe_hold",   int'(pipe_hold),   int'(e[0]));
        check("mem_timeout", int'(mem_timeout), int'(m_timeout));
        check("stall_cnt",   int'(stall_cnt),   m_stall);
        check("flush_cnt",   int'(flush_cnt),   m_flush);
        check("wait_cnt",    int'(wait_cnt),    m_wait);
    endtask

    task automatic model_step();
        if (!rst_n) return;
        if (m_freeze()) begin
            m_wait = sat(m_wait + 1);
            m_run  = m_run + 1;
            if (m_run == WT) m_timeout = 1'b1;
        end else begin
            m_run = 0;
            if (m_flushing()) begin
                m_flush = sat(m_flush + 1);
                if (m_flush_left > 0) m_flush_left--;
                else                  m_flush_left = FC - 1;
            end else if (m_loaduse()) begin
                m_stall = sat(m_stall + 1);
            end
        end
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic ld,
                         input logic b, input logic rq, input logic rd_y);
        id_rs1 = r1; id_rs2 = r2; rs1_used = u1; rs2_used = u2;
        ex_rd = rd; mem_read = ld; br = b; req = rq; rdy = rd_y;
    endtask

    task automatic quiet();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // One clock: check combinational outputs, take the edge, advance the model
    task automatic cycle();
        #1;
        check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use through rs2, then clear
        drive(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1); cycle();
        quiet(); cycle();

        // ex_rd==0 and unused-source cases never stall
        drive(5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1); cycle();
        drive(5'd7, 5'd3, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1); cycle();

        // Branch with load-use present during the flush window
        drive(5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1); cycle();
        drive(5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1); cycle();
        cycle();
        cycle();
        quiet(); cycle();

        // Freeze of 4 cycles starting on flush cycle 2
        quiet(); br = 1'b1; cycle();
        br = 1'b0; req = 1'b1; rdy = 1'b0;
        repeat (4) cycle();
        req = 1'b0; rdy = 1'b1;
        repeat (3) cycle();

        // Timeout: 4 freezes, a gap, 4 freezes keeps flag low; 5 in a row sets it
        quiet(); req = 1'b1; rdy = 1'b0; repeat (4) cycle();
        rdy = 1'b1; cycle();
        rdy = 1'b0; repeat (4) cycle();
        rdy = 1'b1; cycle();
        rdy = 1'b0; repeat (5) cycle();
        rdy = 1'b1; repeat (2) cycle();

        // Asynchronous reset in the middle of a flush window
        quiet(); br = 1'b1; cycle();
        br = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        quiet(); cycle();

        // Randomized traffic, biased toward register matches and short freezes
        for (int i = 0; i < 500; i++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 3));
            drive(($urandom_range(0, 1) != 0) ? rd : 5'($urandom),
                  ($urandom_range(0, 1) != 0) ? rd : 5'($urandom),
                  1'($urandom), 1'($urandom), rd, 1'($urandom),
                  ($urandom_range(0, 9) == 0), 1'($urandom),
                  ($urandom_range(0, 2) != 0));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
